multicycle_control_unit: RTL and testbench

- Multi-cycle successor to the single-cycle control decoder for the RISC-V core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states with req/ready handshakes to instruction and data memory.
- Consumes the PMP checker's fault flag and raises access-fault or illegal-instruction traps with a cause code.
- Adds a parametrised memory-wait timeout.

---
 rtl/multicycle_control_unit_pkg.sv | 43 ++++
 rtl/multicycle_control_unit_if.sv | 24 ++
 rtl/multicycle_control_unit_alu_op_decoder.sv | 35 +++
 rtl/multicycle_control_unit.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_unit_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | cu_pkg : shared encodings for the multi-cycle control unit        |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package cu_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;
    localparam logic [1:0] PC_TRAP   = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_IFAULT  = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0] CAUSE_DFAULT  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | multicycle_control_unit_if : imem/dmem handshake + PMP fault      |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
interface multicycle_control_unit_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;
    logic pmp_fault;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ready, dmem_ready, pmp_fault
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ready, dmem_ready, pmp_fault
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit_alu_op_decoder.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | alu_op_decoder : opcode/funct3/funct7 -> ALU control code         |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module alu_op_decoder
    import cu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_cc
);

    // Only funct7[5] distinguishes SUB from ADD in the supported subset.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        alu_cc = ALU_ADD;
        if (opcode == OP_R) begin
            case (funct3)
                3'b000:  alu_cc = funct7[5] ? ALU_SUB : ALU_ADD;
                3'b111:  alu_cc = ALU_AND;
                3'b110:  alu_cc = ALU_OR;
                3'b010:  alu_cc = ALU_SLT;
                default: alu_cc = ALU_ADD;
            endcase
        end else if (opcode == OP_BR) begin
            alu_cc = ALU_SUB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | multicycle_control_unit : FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer |
// | Optional BEQ/BNE support when CU_BRANCH_EN is defined. Rev 1.0    |
// +-------------------------------------------------------------------+
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [6:0]                       opcode,
    input  logic [2:0]                       funct3,
    input  logic [6:0]                       funct7,
    input  logic                             alu_zero,
    multicycle_control_unit_if.master        mem,
    output logic                             ir_write,
    output logic                             pc_write,
    output logic [1:0]                       pc_src,
    output logic                             reg_write,
    output logic                             alu_src,
    output logic [3:0]                       alu_cc,
    output logic [1:0]                       wb_sel,
    output logic                             trap,
    output logic [1:0]                       trap_cause,
    output logic [2:0]                       state_o
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(MEM_TIMEOUT);

    logic [2:0]       state, next_state;
    logic [1:0]       cause, next_cause;
    logic [TMO_W-1:0] wait_cnt;
    logic [3:0]       dec_cc;
    logic             legal, br_taken, tmo_hit, req_pending;

    alu_op_decoder u_alu_op_decoder (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .alu_cc (dec_cc)
    );

`ifdef CU_BRANCH_EN
    assign br_taken = (funct3 == 3'b000) ? alu_zero : !alu_zero;
`else
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;
    assign br_taken        = 1'b0;
`endif

    always_comb begin
        case (opcode)
            OP_R, OP_I, OP_LW, OP_SW, OP_JALR: legal = 1'b1;
`ifdef CU_BRANCH_EN
            OP_BR:   legal = (funct3 == 3'b000) || (funct3 == 3'b001);
`endif
            default: legal = 1'b0;
        endcase
    end

    // Timeout fires on the last permitted wait cycle; a ready in that cycle still wins.
    assign tmo_hit     = (MEM_TIMEOUT != 0) && (wait_cnt == TMO_LAST);
    assign req_pending = ((state == S_FETCH) && !mem.imem_ready) ||
                         ((state == S_MEM)   && !mem.dmem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            cause    <= CAUSE_NONE;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            cause <= next_cause;
            if (next_state != state)
                wait_cnt <= '0;
            else if (req_pending && (wait_cnt != TMO_MAX))
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        next_cause = cause;
        case (state)
            S_FETCH: begin
                if (mem.pmp_fault || (!mem.imem_ready && tmo_hit)) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_IFAULT;
                end else if (mem.imem_ready) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    next_state = S_EXEC;
                end else begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEM;
                    OP_BR:        next_state = S_FETCH;
                    default:      next_state = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem.pmp_fault || (!mem.dmem_ready && tmo_hit)) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_DFAULT;
                end else if (mem.dmem_ready) begin
                    next_state = (opcode == OP_SW) ? S_FETCH : S_WB;
                end
            end
            default: next_state = S_FETCH;
        endcase
    end

    always_comb begin
        mem.imem_req = (state == S_FETCH);
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_PLUS4;
        reg_write    = 1'b0;
        alu_src      = 1'b0;
        alu_cc       = ALU_ADD;
        wb_sel       = WB_ALU;
        trap         = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    if (mem.imem_ready && !mem.pmp_fault) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                S_EXEC: begin
                    alu_src = (opcode != OP_R);
                    alu_cc  = dec_cc;
                    if (opcode == OP_JALR) begin
                        pc_write = 1'b1;
                        pc_src   = PC_JALR;
                    end else if ((opcode == OP_BR) && br_taken) begin
                        pc_write = 1'b1;
                        pc_src   = PC_BRANCH;
                    end
                end
                S_MEM: begin
                    mem.dmem_req = 1'b1;
                    mem.dmem_we  = (opcode == OP_SW);
                end
                S_WB: begin
                    reg_write = 1'b1;
                    if (opcode == OP_LW)
                        wb_sel = WB_MEM;
                    else if (opcode == OP_JALR)
                        wb_sel = WB_PC4;
                end
                S_TRAP: begin
                    trap     = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_TRAP;
                end
                default: ;
            endcase
        end
    end

    assign trap_cause = cause;
    assign state_o    = state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_multicycle_control_unit : random instructions vs. phase model  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_multicycle_control_unit;

    localparam int TMO = 4;
    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_JALR = 4, K_BR = 5, K_BAD = 6;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       alu_src;
        logic [3:0] alu_cc;
        logic [1:0] wb_sel;
        logic       trap;
        logic [1:0] cause;
    } obs_t;

    typedef struct {
        obs_t  o;
        bit    chk;
        bit    chk_cause;
        string tag;
    } exp_t;

    typedef struct {
        bit rst, ir, dr, pf, az;
    } stim_t;

    typedef struct {
        int         kind;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int         iw, ifault, dw, dfault, az;
    } plan_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       alu_zero;
    logic       ir_write, pc_write, reg_write, alu_src, trap;
    logic [1:0] pc_src, wb_sel, trap_cause;
    logic [3:0] alu_cc;
    logic [2:0] state_o;

    multicycle_control_unit_if mif ();

    multicycle_control_unit #(.MEM_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .alu_zero   (alu_zero),
        .mem        (mif),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .alu_cc     (alu_cc),
        .wb_sel     (wb_sel),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    stim_t tr_s[$];
    exp_t  tr_e[$];
    exp_t  scb[$];
    int    checks = 0;
    int    errors = 0;
    int    inst_no = 0;

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic obs_t idle(input logic [2:0] st);
        obs_t o;
        o        = '0;
        o.st     = st;
        o.alu_cc = 4'b0010;
        return o;
    endfunction

    function automatic logic [3:0] r_alu(input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'd0:    return f7[5] ? 4'b0110 : 4'b0010;
            3'd7:    return 4'b0000;
            3'd6:    return 4'b0001;
            3'd2:    return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("st=%0d ireq=%0b dreq=%0b we=%0b irw=%0b pcw=%0b pcs=%0d rw=%0b asrc=%0b cc=%b wb=%0d trap=%0b cause=%0d",
                         o.st, o.imem_req, o.dmem_req, o.dmem_we, o.ir_write, o.pc_write, o.pc_src,
                         o.reg_write, o.alu_src, o.alu_cc, o.wb_sel, o.trap, o.cause);
    endfunction

    task automatic push(input bit rst, input bit ir, input bit dr, input bit pf, input bit az,
                        input obs_t o, input bit chk, input bit chkc, input string tag);
        stim_t s;
        exp_t  e;
        s.rst = rst; s.ir = ir; s.dr = dr; s.pf = pf; s.az = az;
        e.o = o; e.chk = chk; e.chk_cause = chkc;
        e.tag = $sformatf("i%0d.%s", inst_no, tag);
        tr_s.push_back(s);
        tr_e.push_back(e);
    endtask

    // Expected per-cycle trace of one instruction, phase by phase.
    task automatic build(input plan_t p);
        obs_t o;
        int   tc;
        bit   fin, rdy, flt, az, legal, to_mem, to_wb;
        tr_s.delete();
        tr_e.delete();
        tc = 0; to_mem = 0; to_wb = 0; fin = 0;
        for (int i = 0; !fin; i++) begin
            rdy = (i == p.iw);
            flt = (i == p.ifault);
            o = idle(3'd0);
            o.imem_req = 1'b1;
            if (flt) tc = 1;
            else if (rdy) begin o.ir_write = 1'b1; o.pc_write = 1'b1; end
            else if (i == TMO - 1) tc = 1;
            push(1'b0, rdy, rnd(), flt, rnd(), o, 1'b1, 1'b0, "fetch");
            fin = flt || rdy || (tc != 0);
        end
        if (tc == 0) begin
            legal = (p.kind <= K_JALR);
`ifdef CU_BRANCH_EN
            if (p.kind == K_BR) legal = (p.f3 <= 3'd1);
`endif
            push(1'b0, rnd(), rnd(), rnd(), rnd(), idle(3'd1), 1'b1, 1'b0, "decode");
            if (!legal) tc = 2;
        end
        if (tc == 0) begin
            az = (p.az < 0) ? rnd() : p.az[0];
            o = idle(3'd2);
            o.alu_src = (p.kind != K_R);
            if (p.kind == K_R) o.alu_cc = r_alu(p.f3, p.f7);
            if (p.kind == K_JALR) begin o.pc_write = 1'b1; o.pc_src = 2'd2; end
            if (p.kind == K_BR) begin
                o.alu_cc = 4'b0110;
                if ((p.f3 == 3'd0) ? az : !az) begin o.pc_write = 1'b1; o.pc_src = 2'd1; end
            end
            push(1'b0, rnd(), rnd(), rnd(), az, o, 1'b1, 1'b0, "exec");
            to_mem = (p.kind == K_LW) || (p.kind == K_SW);
            to_wb  = (p.kind == K_R) || (p.kind == K_I) || (p.kind == K_JALR);
        end
        if (to_mem) begin
            fin = 0;
            for (int i = 0; !fin; i++) begin
                rdy = (i == p.dw);
                flt = (i == p.dfault);
                o = idle(3'd3);
                o.dmem_req = 1'b1;
                o.dmem_we  = (p.kind == K_SW);
                if (flt) tc = 3;
                else if (rdy) to_wb = (p.kind == K_LW);
                else if (i == TMO - 1) tc = 3;
                push(1'b0, rnd(), rdy, flt, rnd(), o, 1'b1, 1'b0, "mem");
                fin = flt || rdy || (tc != 0);
            end
        end
        if (tc == 0 && to_wb) begin
            o = idle(3'd4);
            o.reg_write = 1'b1;
            o.wb_sel = (p.kind == K_LW) ? 2'd1 : (p.kind == K_JALR) ? 2'd2 : 2'd0;
            push(1'b0, rnd(), rnd(), rnd(), rnd(), o, 1'b1, 1'b0, "wb");
        end
        if (tc != 0) begin
            o = idle(3'd5);
            o.trap = 1'b1; o.pc_write = 1'b1; o.pc_src = 2'd3; o.cause = 2'(tc);
            push(1'b0, rnd(), rnd(), rnd(), rnd(), o, 1'b1, 1'b1, "trap");
        end
    endtask

    task automatic run_trace();
        stim_t s;
        exp_t  e;
        while (tr_s.size() > 0) begin
            s = tr_s.pop_front();
            e = tr_e.pop_front();
            reset = s.rst;
            mif.imem_ready = s.ir;
            mif.dmem_ready = s.dr;
            mif.pmp_fault  = s.pf;
            alu_zero = s.az;
            scb.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    function automatic plan_t mk(input int kind, input logic [2:0] f3, input logic [6:0] f7,
                                 input int iw, input int ifault, input int dw, input int dfault, input int az);
        plan_t p;
        p.kind = kind; p.f3 = f3; p.f7 = f7;
        p.iw = iw; p.ifault = ifault; p.dw = dw; p.dfault = dfault; p.az = az;
        case (kind)
            K_R:     p.op = 7'b0110011;
            K_I:     p.op = 7'b0010011;
            K_LW:    p.op = 7'b0000011;
            K_SW:    p.op = 7'b0100011;
            K_JALR:  p.op = 7'b1100111;
            K_BR:    p.op = 7'b1100011;
            default: p.op = 7'b1111111;
        endcase
        return p;
    endfunction

    function automatic bit known_op(input logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
               op == 7'b0100011 || op == 7'b1100111 || op == 7'b1100011;
    endfunction

    function automatic plan_t rand_plan();
        plan_t p;
        int    iw, dw;
        iw = $urandom_range(0, 5);
        dw = $urandom_range(0, 5);
        p = mk($urandom_range(0, 6), 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
               iw, ($urandom_range(0, 7) == 0) ? $urandom_range(0, iw) : -1,
               dw, ($urandom_range(0, 7) == 0) ? $urandom_range(0, dw) : -1, -1);
        if (p.kind == K_BR && $urandom_range(0, 3) != 0) p.f3 = 3'($urandom_range(0, 1));
        if (p.kind == K_BAD) begin
            p.op = 7'($urandom_range(0, 127));
            while (known_op(p.op)) p.op = 7'($urandom_range(0, 127));
        end
        return p;
    endfunction

    task automatic do_plan(input plan_t p);
        opcode = p.op; funct3 = p.f3; funct7 = p.f7;
        build(p);
        run_trace();
        inst_no++;
    endtask

    // Monitor: one scoreboard entry per clock, sampled mid-cycle.
    initial begin
        exp_t e;
        obs_t a, m;
        forever begin
            @(negedge clk);
            if (scb.size() > 0) begin
                e = scb.pop_front();
                if (e.chk) begin
                    a = '{state_o, mif.imem_req, mif.dmem_req, mif.dmem_we, ir_write, pc_write, pc_src,
                          reg_write, alu_src, alu_cc, wb_sel, trap, trap_cause};
                    m = e.o;
                    if (!e.chk_cause) begin
                        a.cause = 2'd0;
                        m.cause = 2'd0;
                    end
                    checks++;
                    if (a !== m) begin
                        errors++;
                        $display("FAIL %s: got {%s} expected {%s}", e.tag, fmt(a), fmt(m));
                    end
                end
            end
        end
    end

    initial begin
        obs_t  o;
        plan_t p;
        reset = 1'b1; opcode = 7'b0110011; funct3 = 3'd0; funct7 = 7'd0; alu_zero = 1'b0;
        mif.imem_ready = 1'b0; mif.dmem_ready = 1'b0; mif.pmp_fault = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with ready/fault active: only imem_req may be high.
        o = idle(3'd0);
        o.imem_req = 1'b1;
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, o, 1'b0, 1'b0, "reset");
        push(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, o, 1'b1, 1'b1, "reset");
        push(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, o, 1'b1, 1'b1, "reset");
        run_trace();

        do_plan(mk(K_R,    3'd0, 7'b0100000, 0, -1, 0, -1, -1));
        do_plan(mk(K_LW,   3'd2, 7'd0,       0, -1, 3, -1, -1));
        do_plan(mk(K_SW,   3'd2, 7'd0,       0, -1, 0,  0, -1));
        do_plan(mk(K_R,    3'd7, 7'd0,      10, -1, 0, -1, -1));
        do_plan(mk(K_I,    3'd0, 7'd0,       3, -1, 0, -1, -1));
        do_plan(mk(K_BAD,  3'd0, 7'd0,       0, -1, 0, -1, -1));
        do_plan(mk(K_BR,   3'd0, 7'd0,       0, -1, 0, -1,  1));
        do_plan(mk(K_BR,   3'd1, 7'd0,       1, -1, 0, -1,  1));
        do_plan(mk(K_JALR, 3'd0, 7'd0,       2, -1, 0, -1, -1));
        do_plan(mk(K_R,    3'd0, 7'd0,       0,  0, 0, -1, -1));
        do_plan(mk(K_LW,   3'd2, 7'd0,       0, -1, 9, -1, -1));

        for (int n = 0; n < 80; n++) do_plan(rand_plan());

        // Reset during a MEM wait, after a trap left a non-zero cause behind.
        do_plan(mk(K_R, 3'd0, 7'd0, 1, 1, 0, -1, -1));
        p = mk(K_LW, 3'd2, 7'd0, 0, -1, 20, -1, -1);
        opcode = p.op; funct3 = p.f3; funct7 = p.f7;
        build(p);
        while (tr_s.size() > 4) begin
            void'(tr_s.pop_back());
            void'(tr_e.pop_back());
        end
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, idle(3'd0), 1'b0, 1'b0, "midreset");
        run_trace();
        inst_no++;
        p = mk(K_R, 3'd6, 7'd0, 0, -1, 0, -1, -1);
        opcode = p.op; funct3 = p.f3; funct7 = p.f7;
        build(p);
        tr_e[0].chk_cause = 1'b1;
        tr_e[0].o.cause   = 2'd0;
        run_trace();

        @(negedge clk);
        checks++;
        if (scb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", scb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
